// File: rtl/mux_scan_controller.sv
// Scan controller for a 16:1 MUX: walks all channels, assembles a 16-bit word, hands it off via valid/ready.
// Optional even-parity output is enabled with the MUX_SCAN_PARITY_EN macro.
module mux_scan_controller #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        Clock_In,
  input  logic        Reset_In,
  input  logic        Start_In,
  input  logic        MUX_Data_In,
  input  logic        Word_Ready_In,
  output logic        Enable_Out,
  output logic [3:0]  Select_Out,
  output logic [15:0] Word_Out,
  output logic        Word_Valid_Out,
`ifdef MUX_SCAN_PARITY_EN
  output logic        Parity_Out,
`endif
  output logic        Busy_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [3:0] LAST_SEL = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] cap_q, cap_d;
  logic [15:0] word_q, word_d;
  logic        en_q, en_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        enter_scan;
  logic [15:0] word_full;
`ifdef MUX_SCAN_PARITY_EN
  logic        parity_q, parity_d;
`endif

  // The channel-15 sample goes straight into the delivered word, not via Cap.
  assign word_full = {MUX_Data_In, cap_q[14:0]};

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    cap_d      = cap_q;
    word_d     = word_q;
    en_d       = en_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    enter_scan = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d   = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (Start_In) enter_scan = 1'b1;
      end

      SCAN: begin
        if (cnt_q != SETTLE) begin
          cnt_d = cnt_q + 4'd1;
        end else begin
          cap_d[sel_q] = MUX_Data_In;
          cnt_d        = 4'd0;
          if (sel_q != LAST_SEL) begin
            sel_d = sel_q + 4'd1;
          end else begin
            word_d  = word_full;
            valid_d = 1'b1;
            en_d    = 1'b0;
            sel_d   = 4'd0;
            state_d = DONE;
`ifdef MUX_SCAN_PARITY_EN
            parity_d = ^word_full;
`endif
          end
        end
      end

      DONE: begin
        if (valid_q && Word_Ready_In) begin
          valid_d = 1'b0;
          if (Start_In) begin
            enter_scan = 1'b1;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    // Shared entry actions from IDLE and from a DONE handshake with a new start.
    if (enter_scan) begin
      state_d = SCAN;
      sel_d   = 4'd0;
      cnt_d   = 4'd0;
      en_d    = 1'b1;
      busy_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge Clock_In or posedge Reset_In) begin
    if (Reset_In) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      sel_q    <= 4'd0;
      cap_q    <= 16'd0;
      word_q   <= 16'd0;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cap_q    <= cap_d;
      word_q   <= word_d;
      en_q     <= en_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign Enable_Out     = en_q;
  assign Select_Out     = sel_q;
  assign Word_Out       = word_q;
  assign Word_Valid_Out = valid_q;
  assign Busy_Out       = busy_q;
`ifdef MUX_SCAN_PARITY_EN
  assign Parity_Out     = parity_q;
`endif

endmodule

// File: doc/mux_scan_controller.md
# mux_scan_controller

Sequential scan controller that sits directly upstream and downstream of the 16:1 MUX. It drives the MUX enable and 4-bit select and samples the single-bit MUX output. It walks all 16 channels once per start request and assembles the samples into a 16-bit word. The word is delivered under a valid/ready handshake.

## Interface

Parameters:
- SETTLE_CYCLES, 1, extra cycles each select value is held before its sample is taken; legal range 0..15.

Ports:
- Clock_In  input  1  single clock; all state changes on its rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_In  input  1  scan request; sampled only when idle, or together with a handshake accept in DONE.
- MUX_Data_In  input  1  from MUX_Data_Out of the 16:1 MUX.
- Word_Ready_In  input  1  consumer ready.
- Enable_Out  output  1  to the MUX Enable_In.
- Select_Out  output  4  to the MUX Select_In.
- Word_Out  output  16  assembled word; bit k = channel k sample.
- Word_Valid_Out  output  1  Word_Out holds a new, unaccepted word.
- Busy_Out  output  1  high while in SCAN or DONE.

## Operation

- The FSM has three states: IDLE, SCAN and DONE. The 4-bit settle counter is Cnt. The 16-bit capture register is Cap.
- Reset values: state IDLE, Enable_Out 0, Select_Out 0, Word_Out 0, Word_Valid_Out 0, Busy_Out 0, Cnt 0, Cap 0.
- **IDLE.** If Start_In = 1:
  - go to SCAN;
  - Select_Out <= 0, Cnt <= 0;
  - Enable_Out <= 1, Busy_Out <= 1.
- **SCAN, Cnt != SETTLE_CYCLES:** Cnt <= Cnt + 1.
- **SCAN, Cnt == SETTLE_CYCLES:**
  - Cap[Select_Out] <= MUX_Data_In, Cnt <= 0.
  - If Select_Out != 15: Select_Out <= Select_Out + 1.
  - If Select_Out == 15:
    - Word_Out <= Cap with bit 15 replaced by MUX_Data_In;
    - Word_Valid_Out <= 1, Enable_Out <= 0, Select_Out <= 0;
    - go to DONE.
- **DONE.** A handshake occurs when Word_Valid_Out and Word_Ready_In are both 1 on an edge.
  - On handshake: Word_Valid_Out <= 0.
  - If Start_In = 1 on the same edge, go directly to SCAN with the same entry actions as from IDLE. This gives back-to-back scans with no idle cycle.
  - Otherwise go to IDLE and set Busy_Out <= 0.
- Word_Out changes only on SCAN→DONE. It holds its value through handshake and IDLE until the next scan completes.
- Start_In is ignored in SCAN, and ignored in DONE without a handshake.
- Word_Ready_In is ignored outside DONE.
- Select_Out wraps 15→0 only at the end of a scan. It never increments past 15.
- Reset asserted mid-scan or in DONE:
  - all registers return to reset values immediately, asynchronously;
  - the partial word is discarded and Word_Out returns to 0.
- MUX_Data_In is sampled only while Enable_Out = 1. Its high-Z value while disabled is never captured.

## Timing

- Edge E0 is the edge at which Start_In is accepted.
- Channel k is selected from E0 + k·(SETTLE_CYCLES+1). It is sampled at edge E0 + (k+1)·(SETTLE_CYCLES+1).
- Scan latency is 16·(SETTLE_CYCLES+1) cycles from E0 to Word_Valid_Out rising.
  - SETTLE_CYCLES = 1: 32 cycles.
  - SETTLE_CYCLES = 0: 16 cycles, one channel per clock.
- Enable_Out falls on the same edge that Word_Valid_Out rises.
- Back-to-back throughput is one word per 16·(SETTLE_CYCLES+1) + 1 cycles when Word_Ready_In and Start_In are held high.
- All outputs are registered. No combinational path exists from any input to any output.

## Configuration

- Macro: MUX_SCAN_PARITY_EN.
- **Defined:**
  - adds output Parity_Out (1 bit), reset 0;
  - Parity_Out is registered on the SCAN→DONE edge as the XOR of all 16 bits of the new Word_Out, i.e. even parity;
  - Parity_Out holds its value alongside Word_Out.
- **Undefined:** the port and its logic are absent. All other behaviour is identical.

## Test plan

- **Single scan.** SETTLE_CYCLES = 1, channels driven with pattern 16'hA5C3, Start_In pulsed one cycle.
  - Select_Out steps 0..15, each value held 2 cycles.
  - Word_Valid_Out rises exactly 32 cycles after the Start edge, with Word_Out = 16'hA5C3 and Enable_Out = 0.
- **Handshake stall.** Word_Ready_In held 0 for 10 cycles after valid, and Start_In pulsed during the stall.
  - Word_Valid_Out and Word_Out stay stable and the Start is ignored.
  - Ready = 1 → valid drops next edge; FSM returns to IDLE with Busy_Out = 0.
- **Back-to-back.** SETTLE_CYCLES = 0, Start_In and Word_Ready_In tied 1, patterns 16'h0001 then 16'h8000.
  - Words arrive 17 cycles apart and in order.
  - Enable_Out is low for exactly one cycle between scans.
- **Reset mid-scan.** Reset_In asserted while Select_Out = 7.
  - All outputs go to reset values without a clock edge, and Word_Out = 0.
  - A following Start gives a fresh, correct 32-cycle scan.
- **Start during SCAN.** Extra Start_In pulses at cycles 5 and 20 of a scan.
  - There is no restart and timing is unchanged.
  - Exactly one word is produced.
- **Parity.** With MUX_SCAN_PARITY_EN defined:
  - pattern 16'h0007 → Parity_Out = 1;
  - pattern 16'h0003 → Parity_Out = 0.
  - Both are valid on the same edge as Word_Valid_Out.
